// File: rtl/exec_stage_pkg.sv
// ============================================================================
//  Module      : exec_stage_pkg
//  Description : Instruction indices and shared types for the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_stage_pkg;

    localparam int unsigned NUM_INSTR = 26;

    localparam int unsigned IDX_ADA = 0;
    localparam int unsigned IDX_ADC = 1;
    localparam int unsigned IDX_ADZ = 2;
    localparam int unsigned IDX_AWC = 3;
    localparam int unsigned IDX_ACA = 4;
    localparam int unsigned IDX_ACC = 5;
    localparam int unsigned IDX_ACZ = 6;
    localparam int unsigned IDX_ACW = 7;
    localparam int unsigned IDX_ADI = 8;
    localparam int unsigned IDX_NDU = 9;
    localparam int unsigned IDX_NDC = 10;
    localparam int unsigned IDX_NDZ = 11;
    localparam int unsigned IDX_NCU = 12;
    localparam int unsigned IDX_NCC = 13;
    localparam int unsigned IDX_NCZ = 14;
    localparam int unsigned IDX_LLI = 15;
    localparam int unsigned IDX_LW  = 16;
    localparam int unsigned IDX_SW  = 17;
    localparam int unsigned IDX_LM  = 18;
    localparam int unsigned IDX_SM  = 19;
    localparam int unsigned IDX_BEQ = 20;
    localparam int unsigned IDX_BLT = 21;
    localparam int unsigned IDX_BLE = 22;
    localparam int unsigned IDX_JAL = 23;
    localparam int unsigned IDX_JLR = 24;
    localparam int unsigned IDX_JRI = 25;

    typedef enum logic [0:0] {
        ALU_ADD  = 1'b0,
        ALU_NAND = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic [15:0] result;
        logic        carry;
        logic        zero;
    } alu_out_t;

    // Exactly one instruction selected; anything else is treated as a bubble.
    function automatic logic onehot_legal(input logic [NUM_INSTR-1:0] i_sel);
        return $onehot(i_sel);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_stage_if.sv
// ============================================================================
//  Module      : exec_stage_if
//  Description : Decode-to-execute operands and execute-stage result bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exec_stage_if;

    logic        opcode_valid_i;
    logic [15:0] opcode_pc_i;
    logic [15:0] opcode_instr_i;
    logic [25:0] one_hot_i;
    logic [15:0] operand_val_a;
    logic [15:0] operand_val_b;
    logic [15:0] imm_val_i;
    logic [2:0]  exec_rd_idx_i;

    logic [15:0] exec_wb_val_o;
    logic [2:0]  memu_rd_idx_o;
    logic        wb_en_o;
    logic [15:0] mem_wdata_o;
    logic        load_en_o;
    logic [15:0] opcode_pc_o;
    logic [15:0] opcode_instr_o;
    logic        branch_valid_o;
    logic [15:0] branch_pc_o;
    logic        branch_type_o;
    logic [15:0] current_pc_o;
    logic [15:0] fwd_wb_val_o;
    logic [2:0]  fwd_ex_rd_o;

    modport master (
        output opcode_valid_i, opcode_pc_i, opcode_instr_i, one_hot_i,
               operand_val_a, operand_val_b, imm_val_i, exec_rd_idx_i,
        input  exec_wb_val_o, memu_rd_idx_o, wb_en_o, mem_wdata_o, load_en_o,
               opcode_pc_o, opcode_instr_o, branch_valid_o, branch_pc_o,
               branch_type_o, current_pc_o, fwd_wb_val_o, fwd_ex_rd_o
    );

    modport slave (
        input  opcode_valid_i, opcode_pc_i, opcode_instr_i, one_hot_i,
               operand_val_a, operand_val_b, imm_val_i, exec_rd_idx_i,
        output exec_wb_val_o, memu_rd_idx_o, wb_en_o, mem_wdata_o, load_en_o,
               opcode_pc_o, opcode_instr_o, branch_valid_o, branch_pc_o,
               branch_type_o, current_pc_o, fwd_wb_val_o, fwd_ex_rd_o
    );

endinterface

`default_nettype wire

// File: rtl/exec_alu.sv
// ============================================================================
//  Module      : exec_alu
//  Description : Combinational add/nand unit with carry-out and zero detect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu
    import exec_stage_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_inv_b,
    input  logic        i_cin,
    output alu_out_t    o_res
);

    logic [15:0] w_b;
    logic [16:0] w_sum;
    logic [15:0] w_nand;
    logic [15:0] w_result;

    assign w_b      = i_inv_b ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b} + {16'd0, i_cin};
    assign w_nand   = ~(i_a & w_b);
    assign w_result = (i_op == ALU_NAND) ? w_nand : w_sum[15:0];

    assign o_res.result = w_result;
    assign o_res.carry  = w_sum[16];
    assign o_res.zero   = (w_result == 16'd0);

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// ============================================================================
//  Module      : exec_stage
//  Description : Execute stage: ALU, C/Z flags, branches, LM/SM addressing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_stage
    import exec_stage_pkg::*;
(
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    exec_stage_if.slave   ex
);

    logic [NUM_INSTR-1:0] w_sel;
    logic        w_legal;
    logic        w_add_grp, w_nand_grp, w_adi, w_inv_b, w_use_c;
    logic        w_need_c, w_need_z, w_cond_ok, w_alu_exec;
    logic        w_ms, w_ms_cont, w_wb, w_store, w_load;
    logic        w_eq, w_lt, w_br_taken, w_jump;
    logic [15:0] w_offset, w_mem_addr, w_ms_addr, w_pc_plus2, w_pc_imm, w_jri_tgt;
    logic [15:0] w_alu_b, w_result;
    alu_out_t    w_alu;

    logic        r_c, r_z, r_ms_prev;
    logic [15:0] r_offset;
    logic [15:0] r_wb_val, r_wdata, r_pc, r_instr;
    logic [2:0]  r_rd;
    logic        r_wb_en, r_load;

    assign w_legal = ex.opcode_valid_i & onehot_legal(ex.one_hot_i);
    assign w_sel   = w_legal ? ex.one_hot_i : '0;

    assign w_add_grp  = |w_sel[IDX_ACW:IDX_ADA];
    assign w_nand_grp = |w_sel[IDX_NCZ:IDX_NDU];
    assign w_adi      = w_sel[IDX_ADI];
    assign w_inv_b    = (|w_sel[IDX_ACW:IDX_ACA]) | (|w_sel[IDX_NCZ:IDX_NCU]);
    assign w_use_c    = w_sel[IDX_AWC] | w_sel[IDX_ACW];

    assign w_need_c   = w_sel[IDX_ADC] | w_sel[IDX_ACC] | w_sel[IDX_NDC] | w_sel[IDX_NCC];
    assign w_need_z   = w_sel[IDX_ADZ] | w_sel[IDX_ACZ] | w_sel[IDX_NDZ] | w_sel[IDX_NCZ];
    assign w_cond_ok  = ~(w_need_c & ~r_c) & ~(w_need_z & ~r_z);
    assign w_alu_exec = (w_add_grp | w_adi | w_nand_grp) & w_cond_ok;

    assign w_alu_b = w_adi ? ex.imm_val_i : ex.operand_val_b;

    exec_alu u_alu (
        .i_op    (w_nand_grp ? ALU_NAND : ALU_ADD),
        .i_a     (ex.operand_val_a),
        .i_b     (w_alu_b),
        .i_inv_b (w_inv_b),
        .i_cin   (w_use_c & r_c),
        .o_res   (w_alu)
    );

    // A multi-beat transfer continues only while the same LM/SM stays in EX.
    assign w_ms       = w_sel[IDX_LM] | w_sel[IDX_SM];
    assign w_ms_cont  = w_ms & r_ms_prev & (ex.opcode_pc_i == r_pc);
    assign w_offset   = w_ms_cont ? (r_offset + 16'd2) : 16'd0;

    assign w_mem_addr = ex.operand_val_b + ex.imm_val_i;
    assign w_ms_addr  = ex.operand_val_b + w_offset;
    assign w_pc_plus2 = ex.opcode_pc_i + 16'd2;
    assign w_pc_imm   = ex.opcode_pc_i + ex.imm_val_i;
    assign w_jri_tgt  = ex.operand_val_a + ex.imm_val_i;

    assign w_store = w_sel[IDX_SW] | w_sel[IDX_SM];
    assign w_load  = w_sel[IDX_LW] | w_sel[IDX_LM];
    assign w_wb    = w_alu_exec | w_sel[IDX_LLI] | w_load | w_sel[IDX_JAL] | w_sel[IDX_JLR];

    always_comb begin
        w_result = 16'd0;
        if (w_alu_exec)                        w_result = w_alu.result;
        else if (w_sel[IDX_LLI])               w_result = ex.imm_val_i;
        else if (w_sel[IDX_LW] | w_sel[IDX_SW]) w_result = w_mem_addr;
        else if (w_ms)                         w_result = w_ms_addr;
        else if (w_sel[IDX_JAL] | w_sel[IDX_JLR]) w_result = w_pc_plus2;
        else if (w_sel[IDX_JRI])               w_result = w_jri_tgt;
    end

    assign w_eq       = (ex.operand_val_a == ex.operand_val_b);
    assign w_lt       = ($signed(ex.operand_val_a) < $signed(ex.operand_val_b));
    assign w_br_taken = (w_sel[IDX_BEQ] & w_eq) | (w_sel[IDX_BLT] & w_lt) |
                        (w_sel[IDX_BLE] & (w_lt | w_eq));
    assign w_jump     = w_sel[IDX_JAL] | w_sel[IDX_JLR] | w_sel[IDX_JRI];

    assign ex.branch_valid_o = w_br_taken | w_jump;
    assign ex.branch_type_o  = w_jump;
    assign ex.branch_pc_o    = w_sel[IDX_JLR] ? ex.operand_val_b :
                               w_sel[IDX_JRI] ? w_jri_tgt :
                               (w_br_taken | w_sel[IDX_JAL]) ? w_pc_imm : 16'd0;
    assign ex.current_pc_o   = ex.opcode_pc_i;
    assign ex.fwd_wb_val_o   = w_wb ? w_result : 16'd0;
    assign ex.fwd_ex_rd_o    = w_wb ? ex.exec_rd_idx_i : 3'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_ms_prev <= 1'b0;
            r_offset  <= 16'd0;
            r_wb_val  <= 16'd0;
            r_rd      <= 3'd0;
            r_wb_en   <= 1'b0;
            r_wdata   <= 16'd0;
            r_load    <= 1'b0;
            r_pc      <= 16'd0;
            r_instr   <= 16'd0;
        end else begin
            if (w_alu_exec & (w_add_grp | w_adi)) begin
                r_c <= w_alu.carry;
                r_z <= w_alu.zero;
            end else if (w_alu_exec & w_nand_grp) begin
                r_z <= w_alu.zero;
            end
            r_ms_prev <= w_ms;
            r_offset  <= w_offset;
            r_wb_val  <= w_result;
            r_rd      <= w_wb ? ex.exec_rd_idx_i : 3'd0;
            r_wb_en   <= w_wb;
            r_wdata   <= w_store ? ex.operand_val_a : 16'd0;
            r_load    <= w_load;
            r_pc      <= ex.opcode_pc_i;
            r_instr   <= ex.opcode_instr_i;
        end
    end

    assign ex.exec_wb_val_o  = r_wb_val;
    assign ex.memu_rd_idx_o  = r_rd;
    assign ex.wb_en_o        = r_wb_en;
    assign ex.mem_wdata_o    = r_wdata;
    assign ex.load_en_o      = r_load;
    assign ex.opcode_pc_o    = r_pc;
    assign ex.opcode_instr_o = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
//  Module      : tb_exec_stage
//  Description : Scoreboard bench for exec_stage against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_stage;
    import exec_stage_pkg::*;

    typedef struct {
        int tag;
        bit bv; int bpc; bit bt; int cpc; int fval; int frd;
    } comb_exp_t;

    typedef struct {
        int tag;
        bit wb; bit ld;
        int val; bit chk_val;
        int rd;  bit chk_rd;
        int wdata; bit chk_wdata;
        int pc; int instr; bit chk_pass;
    } reg_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    comb_exp_t cq[$];
    reg_exp_t  rq[$];

    // Reference state: flags and LM/SM beat tracking.
    bit m_c, m_z, m_ms_prev;
    int m_ms_pc, m_beats;

    exec_stage_if u_if ();

    exec_stage u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .ex    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int s16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [25:0] oh,
                              input int idx, input int a, input int b, input int imm,
                              input int pc, input int rd, input int instr,
                              output comb_exp_t ce, output reg_exp_t re);
        bit legal, wr, ld, st, taken, jmp, ok, upd_c, upd_z, nc, nz, is_ms;
        int res, s, bb, tgt, beats;
        legal = v && ($countones(oh) == 1);
        wr = 0; ld = 0; st = 0; taken = 0; jmp = 0; upd_c = 0; upd_z = 0;
        nc = 0; nz = 0; is_ms = 0; res = 0; tgt = 0; beats = 0;
        ok = 1;
        if (legal) begin
            if (idx inside {IDX_ADC, IDX_ACC, IDX_NDC, IDX_NCC}) ok = m_c;
            if (idx inside {IDX_ADZ, IDX_ACZ, IDX_NDZ, IDX_NCZ}) ok = m_z;
            if (idx <= IDX_ADI) begin
                bb = (idx == IDX_ADI) ? imm : ((idx >= IDX_ACA) ? 65535 - b : b);
                s  = a + bb + (((idx == IDX_AWC) || (idx == IDX_ACW)) ? int'(m_c) : 0);
                if (ok) begin
                    res = s % 65536; wr = 1; upd_c = 1; upd_z = 1;
                    nc = (s >= 65536); nz = (res == 0);
                end
            end else if (idx <= IDX_NCZ) begin
                bb = (idx >= IDX_NCU) ? 65535 - b : b;
                if (ok) begin
                    res = 65535 - (a & bb); wr = 1; upd_z = 1; nz = (res == 0);
                end
            end else if (idx == IDX_LLI) begin
                res = imm; wr = 1;
            end else if (idx == IDX_LW || idx == IDX_SW) begin
                res = (b + imm) % 65536;
                if (idx == IDX_LW) begin wr = 1; ld = 1; end else st = 1;
            end else if (idx == IDX_LM || idx == IDX_SM) begin
                is_ms = 1;
                beats = (m_ms_prev && pc == m_ms_pc) ? m_beats + 1 : 0;
                res = (b + 2 * beats) % 65536;
                if (idx == IDX_LM) begin wr = 1; ld = 1; end else st = 1;
            end else if (idx == IDX_BEQ) begin
                taken = (a == b); tgt = (pc + imm) % 65536;
            end else if (idx == IDX_BLT) begin
                taken = (s16(a) < s16(b)); tgt = (pc + imm) % 65536;
            end else if (idx == IDX_BLE) begin
                taken = (s16(a) <= s16(b)); tgt = (pc + imm) % 65536;
            end else begin
                jmp = 1;
                if (idx == IDX_JAL) begin tgt = (pc + imm) % 65536; res = (pc + 2) % 65536; wr = 1; end
                else if (idx == IDX_JLR) begin tgt = b; res = (pc + 2) % 65536; wr = 1; end
                else tgt = (a + imm) % 65536;
            end
        end
        ce.bv = taken || jmp; ce.bpc = tgt; ce.bt = jmp; ce.cpc = pc;
        ce.fval = wr ? res : 0; ce.frd = wr ? rd : 0;
        if (r) begin
            re.wb = 0; re.ld = 0; re.val = 0; re.rd = 0; re.wdata = 0; re.pc = 0; re.instr = 0;
            re.chk_val = 1; re.chk_rd = 1; re.chk_wdata = 1; re.chk_pass = 1;
            m_c = 0; m_z = 0; m_ms_prev = 0; m_ms_pc = 0; m_beats = 0;
        end else begin
            re.wb = wr; re.ld = ld; re.val = res; re.chk_val = wr || st;
            re.rd = rd; re.chk_rd = wr; re.wdata = a; re.chk_wdata = st;
            re.pc = pc; re.instr = instr; re.chk_pass = legal;
            if (upd_c) m_c = nc;
            if (upd_z) m_z = nz;
            m_ms_prev = legal && is_ms; m_ms_pc = pc; m_beats = beats;
        end
    endtask

    task automatic issue(input bit r, input bit v, input int idx, input int a, input int b,
                         input int imm, input int pc, input int rd, input int mode);
        logic [25:0] oh;
        int          j, instr;
        comb_exp_t   ce;
        reg_exp_t    re;
        instr = $urandom_range(0, 65535);
        oh = '0;
        oh[idx] = 1'b1;
        if (mode == 1) oh = '0;
        if (mode == 2) begin
            j = (idx + 1 + $urandom_range(0, 24)) % 26;
            oh[j] = 1'b1;
        end
        @(posedge clk); #1;
        u_if.opcode_valid_i = v;
        u_if.opcode_pc_i    = pc[15:0];
        u_if.opcode_instr_i = instr[15:0];
        u_if.one_hot_i      = oh;
        u_if.operand_val_a  = a[15:0];
        u_if.operand_val_b  = b[15:0];
        u_if.imm_val_i      = imm[15:0];
        u_if.exec_rd_idx_i  = rd[2:0];
        model_step(r, v, oh, idx, a, b, imm, pc, rd, instr, ce, re);
        ce.tag = cyc; re.tag = cyc;
        cq.push_back(ce);
        rq.push_back(re);
        if (r && !rst) begin
            @(negedge clk); #1;
            rst = 1'b1;
        end else begin
            rst = r;
        end
    endtask

    // Monitor: combinational outputs of this cycle, registered outputs of the last.
    always @(negedge clk) begin : monitor
        comb_exp_t ce;
        reg_exp_t  re;
        if (cq.size() > 0 && cq[0].tag == cyc) begin
            ce = cq.pop_front();
            chk("branch_valid", int'(u_if.branch_valid_o), int'(ce.bv));
            if (ce.bv) begin
                chk("branch_pc", int'(u_if.branch_pc_o), ce.bpc);
                chk("branch_type", int'(u_if.branch_type_o), int'(ce.bt));
            end
            chk("current_pc", int'(u_if.current_pc_o), ce.cpc);
            chk("fwd_wb_val", int'(u_if.fwd_wb_val_o), ce.fval);
            chk("fwd_ex_rd", int'(u_if.fwd_ex_rd_o), ce.frd);
        end
        while (rq.size() > 0 && rq[0].tag < cyc) begin
            re = rq.pop_front();
            chk("wb_en", int'(u_if.wb_en_o), int'(re.wb));
            chk("load_en", int'(u_if.load_en_o), int'(re.ld));
            if (re.chk_val)   chk("exec_wb_val", int'(u_if.exec_wb_val_o), re.val);
            if (re.chk_rd)    chk("memu_rd_idx", int'(u_if.memu_rd_idx_o), re.rd);
            if (re.chk_wdata) chk("mem_wdata", int'(u_if.mem_wdata_o), re.wdata);
            if (re.chk_pass) begin
                chk("opcode_pc_o", int'(u_if.opcode_pc_o), re.pc);
                chk("opcode_instr_o", int'(u_if.opcode_instr_o), re.instr);
            end
        end
    end

    initial begin : driver
        int  idx, a, b, imm, pc, mode;
        bit  v, last_ms;
        n_checks = 0; n_fail = 0;
        m_c = 0; m_z = 0; m_ms_prev = 0; m_ms_pc = 0; m_beats = 0;
        rst = 1'b1;
        u_if.opcode_valid_i = 0; u_if.opcode_pc_i = 0; u_if.opcode_instr_i = 0;
        u_if.one_hot_i = '0; u_if.operand_val_a = 0; u_if.operand_val_b = 0;
        u_if.imm_val_i = 0; u_if.exec_rd_idx_i = 0;

        issue(1, 0, 0, 0, 0, 0, 0, 0, 1);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Flag chain and conditional skip
        issue(0, 1, IDX_ADA, 'hFFFF, 'h0003, 0, 'h0100, 1, 0);
        issue(0, 1, IDX_ADC, 'h0000, 'h0000, 0, 'h0102, 2, 0);
        issue(0, 1, IDX_ADZ, 'hFFFF, 'h0001, 0, 'h0104, 3, 0);
        issue(0, 1, IDX_AWC, 'hFFFE, 'h0001, 0, 'h0106, 4, 0);
        issue(0, 1, IDX_ADA, 'h0001, 'h0001, 0, 'h0108, 5, 0);
        issue(0, 1, IDX_NDC, 'h1234, 'h00FF, 0, 'h010A, 6, 0);
        issue(0, 1, IDX_NDU, 'hFFFF, 'hFFFF, 0, 'h010C, 7, 0);
        issue(0, 1, IDX_NDZ, 'h0F0F, 'h00FF, 0, 'h010E, 1, 0);
        // Memory
        issue(0, 1, IDX_LW,  'h0000, 'h1000, 'h0004, 'h0110, 2, 0);
        issue(0, 1, IDX_SW,  'h5055, 'h0200, 'h0008, 'h0112, 0, 0);
        for (int i = 0; i < 3; i++) issue(0, 1, IDX_LM, 'h0000, 'h2000, 0, 'h0120, 3, 0);
        // Branches and jumps
        issue(0, 1, IDX_BEQ, 'h0007, 'h0007, 'h0020, 'h0128, 0, 0);
        issue(0, 1, IDX_BLT, 'h8000, 'h0001, 'h0004, 'h0130, 0, 0);
        issue(0, 1, IDX_BLE, 'h0002, 'hFFFC, 'h0010, 'h0132, 0, 0);
        issue(0, 1, IDX_JAL, 'h0000, 'h0000, 'h0020, 'h0138, 4, 0);
        issue(0, 1, IDX_JLR, 'h0000, 'hABCD, 'h0000, 'h013A, 5, 0);
        issue(0, 1, IDX_JRI, 'h1000, 'h0000, 'h0040, 'h013C, 6, 0);
        // Reset in the middle of an SM sequence
        issue(0, 1, IDX_SM, 'h1111, 'h3000, 0, 'h0200, 0, 0);
        issue(0, 1, IDX_SM, 'h2222, 'h3000, 0, 'h0200, 0, 0);
        issue(1, 1, IDX_SM, 'h3333, 'h3000, 0, 'h0200, 0, 0);
        issue(0, 1, IDX_SM, 'h4444, 'h3000, 0, 'h0200, 0, 0);
        issue(0, 1, IDX_SM, 'h5555, 'h3000, 0, 'h0200, 0, 0);

        last_ms = 0; idx = 0; pc = 0;
        for (int n = 0; n < 600; n++) begin
            a = $urandom_range(0, 65535);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 65535);
            imm = $urandom_range(0, 65535);
            case ($urandom_range(0, 9))
                0: begin a = 0; b = 0; end
                1: begin a = 'hFFFF; b = 'hFFFF; end
                default: ;
            endcase
            if (last_ms && $urandom_range(0, 3) != 0) begin
                v = 1; mode = 0;
            end else begin
                idx  = $urandom_range(0, 25);
                pc   = $urandom_range(0, 32767) * 2;
                v    = ($urandom_range(0, 9) != 0);
                mode = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
            end
            issue(0, v, idx, a, b, imm, pc, $urandom_range(0, 7), mode);
            last_ms = v && (mode == 0) && (idx == IDX_LM || idx == IDX_SM);
        end

        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drained", cq.size() + rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
